// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller: synchronised rising-edge capture into
// per-source pending flags, enable masking, lowest-index-first request/ack handshake.
module irq_controller #(
  parameter int unsigned NSRC = 4
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  input  logic            ExtIAck,
  output logic            ExtIRQ,
  output logic [2:0]      irq_id,
  output logic [NSRC-1:0] pending,
  output logic [7:0]      serviced_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [NSRC-1:0] sync1_q, sync2_q, dly_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [NSRC-1:0] rise, active;
  logic [1:0]      state_q, state_d;
  logic [2:0]      irq_id_q, irq_id_d, lowest;
  logic [7:0]      serviced_cnt_q, serviced_cnt_d;
  logic            any_active, ack_take;

  always_comb begin
    rise       = sync2_q & ~dly_q;
    active     = pending_q & enable_q;
    lowest     = '0;
    any_active = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (active[i] && !any_active) begin
        lowest     = 3'(i);
        any_active = 1'b1;
      end
    end

    state_d        = state_q;
    irq_id_d       = irq_id_q;
    serviced_cnt_d = serviced_cnt_q;
    ack_take       = 1'b0;
    enable_d       = mask_we ? mask_wdata : enable_q;

    case (state_q)
      ST_IDLE: begin
        if (any_active) begin
          irq_id_d = lowest;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        // Once raised, the request is held regardless of mask or new lower-index sources.
        if (ExtIAck) begin
          ack_take       = 1'b1;
          serviced_cnt_d = serviced_cnt_q + 8'd1;
          state_d        = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!ExtIAck) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    pending_d = pending_q;
    if (ack_take) begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (3'(i) == irq_id_q) pending_d[i] = 1'b0;
      end
    end
    // A fresh edge on the same cycle as its ack keeps the flag set.
    pending_d = pending_d | rise;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      dly_q          <= '0;
      pending_q      <= '0;
      enable_q       <= '1;
      state_q        <= ST_IDLE;
      irq_id_q       <= '0;
      serviced_cnt_q <= '0;
    end else begin
      sync1_q        <= irq_in;
      sync2_q        <= sync1_q;
      dly_q          <= sync2_q;
      pending_q      <= pending_d;
      enable_q       <= enable_d;
      state_q        <= state_d;
      irq_id_q       <= irq_id_d;
      serviced_cnt_q <= serviced_cnt_d;
    end
  end

  assign ExtIRQ       = (state_q == ST_REQ);
  assign irq_id       = irq_id_q;
  assign pending      = pending_q;
  assign serviced_cnt = serviced_cnt_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller (NSRC=4): latency, priority, masking,
// held ack, ack/edge collision, asynchronous reset and counter wrap.
module tb_irq_controller;

  logic       CLOCK_50;
  logic       reset;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       ExtIAck;
  logic       ExtIRQ;
  logic [2:0] irq_id;
  logic [3:0] pending;
  logic [7:0] serviced_cnt;

  int checks = 0;
  int errors = 0;

  irq_controller #(.NSRC(4)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .irq_in       (irq_in),
    .mask_we      (mask_we),
    .mask_wdata   (mask_wdata),
    .ExtIAck      (ExtIAck),
    .ExtIRQ       (ExtIRQ),
    .irq_id       (irq_id),
    .pending      (pending),
    .serviced_cnt (serviced_cnt)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle_low();
    irq_in = 4'b0000;
    tick(); tick(); tick();
  endtask

  initial begin
    int n;
    reset = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; ExtIAck = 1'b0;
    #1;
    chk("rst_irq", ExtIRQ, 1'b0);
    chk("rst_id", irq_id, 3'd0);
    chk("rst_pend", pending, 4'b0000);
    chk("rst_cnt", serviced_cnt, 8'd0);
    tick(); tick();
    reset = 1'b0;

    // Single source latency
    irq_in = 4'b0001;
    tick(); chk("lat_e1_pend", pending, 4'b0000);
    tick(); chk("lat_e2_pend", pending, 4'b0000);
    tick(); chk("lat_e3_pend", pending, 4'b0001); chk("lat_e3_irq", ExtIRQ, 1'b0);
    tick(); chk("lat_e4_irq", ExtIRQ, 1'b1); chk("lat_e4_id", irq_id, 3'd0);
    ExtIAck = 1'b1;
    tick(); chk("s1_pend", pending, 4'b0000); chk("s1_cnt", serviced_cnt, 8'd1);
    chk("s1_irq", ExtIRQ, 1'b0);
    ExtIAck = 1'b0;
    tick();
    settle_low();

    // Priority
    irq_in = 4'b1010;
    tick(); tick(); tick(); chk("pri_pend", pending, 4'b1010);
    tick(); chk("pri_irq1", ExtIRQ, 1'b1); chk("pri_id1", irq_id, 3'd1);
    ExtIAck = 1'b1;
    tick(); chk("pri_pend1", pending, 4'b1000); chk("pri_cnt1", serviced_cnt, 8'd2);
    ExtIAck = 1'b0;
    tick(); chk("pri_idle", ExtIRQ, 1'b0);
    tick(); chk("pri_irq2", ExtIRQ, 1'b1); chk("pri_id2", irq_id, 3'd3);
    ExtIAck = 1'b1;
    tick(); chk("pri_pend2", pending, 4'b0000); chk("pri_cnt2", serviced_cnt, 8'd3);
    ExtIAck = 1'b0;
    tick();
    settle_low();

    // Masking
    mask_we = 1'b1; mask_wdata = 4'b1011;
    tick(); mask_we = 1'b0;
    irq_in = 4'b0100;
    tick(); tick(); tick(); chk("msk_pend", pending, 4'b0100);
    tick(); chk("msk_irq_a", ExtIRQ, 1'b0);
    tick(); chk("msk_irq_b", ExtIRQ, 1'b0);
    mask_we = 1'b1; mask_wdata = 4'b1111;
    tick(); mask_we = 1'b0; chk("msk_w_irq", ExtIRQ, 1'b0);
    tick(); chk("msk_irq", ExtIRQ, 1'b1); chk("msk_id", irq_id, 3'd2);
    mask_we = 1'b1; mask_wdata = 4'b0000;
    tick(); mask_we = 1'b0;
    chk("hold_mask_irq", ExtIRQ, 1'b1); chk("hold_mask_id", irq_id, 3'd2);
    irq_in = 4'b0101; mask_we = 1'b1; mask_wdata = 4'b1111;
    tick(); mask_we = 1'b0;
    tick(); tick();
    chk("hold_low_pend", pending, 4'b0101);
    chk("hold_low_irq", ExtIRQ, 1'b1); chk("hold_low_id", irq_id, 3'd2);
    ExtIAck = 1'b1;
    tick(); chk("msk_ack_pend", pending, 4'b0001); chk("msk_ack_cnt", serviced_cnt, 8'd4);
    ExtIAck = 1'b0;
    tick();
    tick(); chk("msk_next_id", irq_id, 3'd0); chk("msk_next_irq", ExtIRQ, 1'b1);
    ExtIAck = 1'b1;
    tick(); chk("msk_next_cnt", serviced_cnt, 8'd5);
    ExtIAck = 1'b0;
    tick();
    settle_low();

    // Held ack
    irq_in = 4'b0011;
    tick(); tick(); tick(); tick();
    chk("ha_irq", ExtIRQ, 1'b1); chk("ha_id", irq_id, 3'd0);
    ExtIAck = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ha_pend", pending, 4'b0010);
      chk("ha_cnt", serviced_cnt, 8'd6);
      chk("ha_irq_low", ExtIRQ, 1'b0);
    end
    ExtIAck = 1'b0;
    tick(); chk("ha_rel_irq", ExtIRQ, 1'b0);
    tick(); chk("ha_next_irq", ExtIRQ, 1'b1); chk("ha_next_id", irq_id, 3'd1);
    ExtIAck = 1'b1;
    tick(); chk("ha_next_cnt", serviced_cnt, 8'd7); chk("ha_next_pend", pending, 4'b0000);
    ExtIAck = 1'b0;
    tick();
    settle_low();

    // Collision of new edge with ack
    irq_in = 4'b0001;
    tick(); tick(); tick(); tick();
    chk("col_irq", ExtIRQ, 1'b1); chk("col_id", irq_id, 3'd0);
    irq_in = 4'b0000;
    tick(); tick(); tick();
    irq_in = 4'b0001;
    tick(); tick();
    ExtIAck = 1'b1;
    tick(); chk("col_pend", pending, 4'b0001); chk("col_cnt", serviced_cnt, 8'd8);
    ExtIAck = 1'b0;
    tick();
    tick(); chk("col_rereq", ExtIRQ, 1'b1); chk("col_reid", irq_id, 3'd0);
    ExtIAck = 1'b1;
    tick(); chk("col_cnt2", serviced_cnt, 8'd9); chk("col_pend2", pending, 4'b0000);
    ExtIAck = 1'b0;
    tick();

    // Asynchronous reset mid-request
    irq_in = 4'b1001;
    tick(); tick(); tick(); tick();
    chk("ar_irq", ExtIRQ, 1'b1); chk("ar_id", irq_id, 3'd3);
    mask_we = 1'b1; mask_wdata = 4'b0000;
    tick(); mask_we = 1'b0;
    chk("ar_hold", ExtIRQ, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("ar_irq0", ExtIRQ, 1'b0); chk("ar_id0", irq_id, 3'd0);
    chk("ar_pend0", pending, 4'b0000); chk("ar_cnt0", serviced_cnt, 8'd0);
    tick();
    reset = 1'b0;
    tick(); tick(); chk("pr_pend_e2", pending, 4'b0000);
    tick(); chk("pr_pend_e3", pending, 4'b1001);
    tick(); chk("pr_irq", ExtIRQ, 1'b1); chk("pr_id", irq_id, 3'd0);
    ExtIAck = 1'b1;
    tick(); chk("pr_cnt1", serviced_cnt, 8'd1); chk("pr_pend1", pending, 4'b1000);
    ExtIAck = 1'b0;
    tick();
    tick(); chk("pr_id2", irq_id, 3'd3);
    ExtIAck = 1'b1;
    tick(); chk("pr_cnt2", serviced_cnt, 8'd2);
    ExtIAck = 1'b0;
    tick();
    settle_low();

    // Counter wrap: 254 more services take the count from 2 back to 0
    for (int k = 0; k < 254; k++) begin
      irq_in = 4'b0001;
      n = 0;
      while (ExtIRQ !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      chk("wrap_req", ExtIRQ, 1'b1);
      ExtIAck = 1'b1;
      tick();
      chk("wrap_cnt", serviced_cnt, 32'((k + 3) % 256));
      ExtIAck = 1'b0;
      tick();
      settle_low();
    end
    chk("wrap_zero", serviced_cnt, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
